instruction_memory: RTL
=======================

INSTRUCTION_MEMORY -- requirements
Module: instruction_memory

Interface
REQ-001 Parameter: LATENCY, default 4, number of clock edges from request acceptance to data-valid; legal range 1..15.
REQ-002 Parameter: DEPTH_LOG2, default 8, log2 of the word count; the default gives 256 words of 32 bits.
REQ-003 Port: CLK  input  1  sole clock; all state changes on rising edge.
REQ-004 Port: RESET  input  1  asynchronous, active-low reset.
REQ-005 Port: READ  input  1  fetch request from the CPU; held high until BUSYWAIT falls.
REQ-006 Port: ADDRESS  input  32  byte address (CPU PC).
REQ-007 Port: READDATA  output  32  fetched instruction word.
REQ-008 Port: BUSYWAIT  output  1  high while a request is pending and not yet answered.
REQ-009 Port: ERROR  output  1  high during the response cycle of a faulted request.
REQ-010 Port: LOAD_EN  input  1  preload write strobe.
REQ-011 Port: LOAD_ADDR  input  DEPTH_LOG2  preload word index.
REQ-012 Port: LOAD_DATA  input  32  preload word.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, BUSY and RESP.
REQ-014 In IDLE, a rising edge with READ=1 SHALL accept a request: latch ADDRESS, load counter with LATENCY-1, go to BUSY.
REQ-015 In BUSY, each edge with counter≠0 SHALL decrement the counter.
REQ-016 In BUSY, an edge with counter=0 SHALL load READDATA = mem[latched ADDRESS[DEPTH_LOG2+1:2]] and go to RESP.
REQ-017 Data SHALL therefore be valid exactly LATENCY edges after the accepting edge; LATENCY=1 needs no special case.
REQ-018 RESP SHALL last exactly one cycle, and the next edge SHALL always go to IDLE.
REQ-019 A request arriving in the RESP cycle SHALL NOT be accepted there; back-to-back fetches take LATENCY+2 cycles each.
REQ-020 BUSYWAIT SHALL be combinational: READ AND (state≠RESP).
REQ-021 BUSYWAIT SHALL be 0 whenever READ=0.
REQ-022 ADDRESS changes after acceptance SHALL be ignored; only the latched address is used.
REQ-023 READ falling while in BUSY SHALL abort the request: the next edge goes to IDLE, and READDATA and ERROR stay unchanged.
REQ-024 A request SHALL fault when ADDRESS[1:0]≠0 or ADDRESS[31:DEPTH_LOG2+2]≠0.
REQ-025 A faulted request SHALL go from IDLE directly to RESP at the accepting edge, with READDATA=0x00000000 and ERROR=1.
REQ-026 ERROR SHALL be 0 in every state except the RESP state of a faulted request.
REQ-027 READDATA SHALL hold its last value outside RESP.
REQ-028 LOAD_EN=1 at an edge SHALL write mem[LOAD_ADDR]=LOAD_DATA only when state=IDLE and READ=0; otherwise the write is dropped.
REQ-029 A dropped preload write SHALL leave the array unchanged.
REQ-030 A preload write SHALL be visible to any request accepted on a later edge.

Reset
REQ-031 RESET=0 SHALL immediately, independent of CLK, force state=IDLE, counter=0, READDATA=0x00000000 and ERROR=0.
REQ-032 BUSYWAIT SHALL follow REQ-020 during reset.
REQ-033 Reset mid-request SHALL discard that request with no response.
REQ-034 The memory array SHALL NOT be cleared by reset.
REQ-035 After RESET rises, the first edge SHALL be able to accept a request.

Verification (LATENCY=4 unless stated)
REQ-036 Preload mem[3]=0x00020005, then hold READ=1 with ADDRESS=0x0000000C: BUSYWAIT=1 through the 4th edge after acceptance, then READDATA=0x00020005, BUSYWAIT=0, ERROR=0 for one cycle, then IDLE.
REQ-037 Two consecutive fetches at 0x0 and 0x4: the second is accepted at the edge ending RESP+1, and each data-valid is 6 cycles apart.
REQ-038 ADDRESS=0x00000006 (misaligned) and, separately, ADDRESS=0x00000400 (out of range): RESP follows the accepting edge with READDATA=0 and ERROR=1.
REQ-039 Drop READ after 2 BUSY edges: no RESP, READDATA unchanged; also assert RESET=0 mid-BUSY: outputs clear with no clock edge needed.
REQ-040 LOAD_EN during BUSY to word 5 is dropped (a later read returns the old value); LOAD_EN in IDLE is accepted.
REQ-041 With LATENCY=1, a read is data-valid 1 edge after acceptance.

Source files
------------

// File: rtl/instruction_memory.sv
// Instruction fetch memory with a fixed access latency, alignment/range fault
// detection and a side-band preload port for filling the array before execution.
module instruction_memory #(
    parameter int LATENCY    = 4,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  READ,
    input  logic [31:0]           ADDRESS,
    output logic [31:0]           READDATA,
    output logic                  BUSYWAIT,
    output logic                  ERROR,
    input  logic                  LOAD_EN,
    input  logic [DEPTH_LOG2-1:0] LOAD_ADDR,
    input  logic [31:0]           LOAD_DATA
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state_reg;
    state_t                  state_next;
    logic [3:0]              count_reg;
    logic [DEPTH_LOG2-1:0]   word_idx_reg;
    logic [31:0]             readdata_reg;
    logic                    error_reg;
    logic                    req_fault;

    logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];

    // Misaligned PCs and anything past the last word are answered with an error.
    assign req_fault = (ADDRESS[1:0] != 2'b00) ||
                       ((ADDRESS >> (DEPTH_LOG2 + 2)) != 32'd0);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (READ) begin
                    state_next = req_fault ? RESP : BUSY;
                end
            end
            BUSY: begin
                if (!READ) begin
                    state_next = IDLE;
                end else if (count_reg == 4'd0) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        BUSYWAIT = READ && (state_reg != RESP);
        READDATA = readdata_reg;
        ERROR    = error_reg;
    end

    // Counter starts at LATENCY-1 so the data edge lands exactly LATENCY edges after acceptance.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            count_reg    <= 4'd0;
            word_idx_reg <= '0;
            readdata_reg <= 32'd0;
            error_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (READ) begin
                        word_idx_reg <= ADDRESS[DEPTH_LOG2+1:2];
                        count_reg    <= 4'(LATENCY - 1);
                        if (req_fault) begin
                            readdata_reg <= 32'd0;
                            error_reg    <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (READ) begin
                        if (count_reg != 4'd0) begin
                            count_reg <= count_reg - 4'd1;
                        end else begin
                            readdata_reg <= mem[word_idx_reg];
                            error_reg    <= 1'b0;
                        end
                    end
                end
                RESP:    error_reg <= 1'b0;
                default: error_reg <= 1'b0;
            endcase
        end
    end

    // Preload is only honoured while the fetch side is completely quiet.
    always_ff @(posedge CLK) begin
        if (LOAD_EN && (state_reg == IDLE) && !READ) begin
            mem[LOAD_ADDR] <= LOAD_DATA;
        end
    end

endmodule
